mul_hilo_ctrl: RTL and testbench
================================

Name: mul_hilo_ctrl

Overview:
Sequential control and writeback stage that sits directly around the combinational Booth multiplier.
- Captures 32-bit signed operands on a start request and holds them stable on the multiplier inputs for a fixed settling window.
- Writes the 64-bit product into the HI/LO register pair.
- Serves HI/LO reads onto the 32-bit datapath bus with a registered one-cycle valid.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
LAT, 2, settling cycles before product capture; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a multiply; sampled only in IDLE.
m_in  input  WIDTH  signed multiplicand.
q_in  input  WIDTH  signed multiplier.
mul_m  output  WIDTH  registered multiplicand to the multiplier's M port.
mul_q  output  WIDTH  registered multiplier to the multiplier's Q port.
mul_result  input  2*WIDTH  product from the multiplier's Result port.
busy  output  1  high in WAIT and WRITE.
done  output  1  one-cycle pulse after HI/LO are updated.
hi  output  WIDTH  HI register (product[63:32]).
lo  output  WIDTH  LO register (product[31:0]).
rd_hi  input  1  read request for HI (MFHI).
rd_lo  input  1  read request for LO (MFLO).
bus_out  output  WIDTH  registered read data.
bus_valid  output  1  high for one cycle when bus_out holds read data.

Behaviour:
Reset (rst_n low, asynchronous):
- state=IDLE; mul_m, mul_q, hi, lo, bus_out = 0; busy, done, bus_valid = 0; counter = 0.

FSM states IDLE, WAIT, WRITE:
- IDLE, start=1 at edge k: mul_m<=m_in, mul_q<=q_in, counter<=LAT-1, go to WAIT.
- WAIT: counter decrements each edge. When counter==0, go to WRITE. WAIT therefore lasts exactly LAT cycles.
- WRITE (one cycle): at the exiting edge, hi<=mul_result[63:32], lo<=mul_result[31:0], done<=1, go to IDLE.
- done is high in the first IDLE cycle, i.e. LAT+2 cycles after the start edge.

Operands and product:
- mul_m/mul_q hold until the next accepted start. They are not cleared on completion.
- start while busy is ignored; it is neither queued nor does it disturb the operands.
- start in the same cycle done is high is accepted normally, giving back-to-back operation.
- No sign/width manipulation of the product; it is stored bit-exact.

Read path (independent of the FSM):
- rd_hi or rd_lo sampled at edge n → bus_out and bus_valid=1 valid after edge n, for one cycle.
- Both asserted → HI wins; the LO request is dropped.
- Neither asserted → bus_valid=0 and bus_out holds its last value.
- A read sampled on the same edge as the WRITE update returns the pre-update value.
- Reads during WAIT return the previous product.

Mid-operation reset: returns to IDLE immediately and zeroes HI/LO. No done is issued.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT=2'd1, WRITE=2'd2), WIDTH default, counter width 4.
- One natural sub-module, hilo_regs: HI/LO storage plus read mux and bus_valid register. The FSM and operand registers stay in the top level.
- The Booth multiplier is connected externally in the bench, not instantiated inside.

Test Plan:
1. Reset mid-WAIT (start, then rst_n low one cycle later) → state IDLE, hi=lo=0, busy=0, no done pulse.
2. m_in=0xFFFFFFCB (-53), q_in=0xFFFFFFC2 (-62), LAT=2, start → busy for 3 cycles, done pulse 4 cycles after start edge; hi=0x00000000, lo=0x00000CD6; rd_lo → bus_out=0x00000CD6, bus_valid 1 cycle.
3. m_in=0x7FFFFFFF, q_in=0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001. Then m_in=0xFFFFFFFF, q_in=0x00000001 started in the done cycle → hi=lo=0xFFFFFFFF.
4. start pulsed again during WAIT with different operands → mul_m/mul_q unchanged, single done pulse, product from the first operands only.
5. rd_hi and rd_lo together after test 3 → bus_out=0xFFFFFFFF from HI, one valid cycle. rd_lo on the WRITE edge of a new multiply → old lo value returned.
6. LAT=1 and LAT=15 builds → done exactly LAT+2 cycles after the start edge, correct product each.

Source files
------------

// File: rtl/mul_hilo_ctrl_pkg.sv
// rtl/mul_hilo_ctrl_pkg.sv - shared state encoding and sizing for the multiply control stage
package mul_hilo_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_hilo_ctrl_hilo_regs.sv
// rtl/mul_hilo_ctrl_hilo_regs.sv - HI/LO product storage with registered read port
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic                 rd_hi,
    input  logic                 rd_lo,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid
);

    logic [WIDTH-1:0] hi_q, lo_q, bus_q;
    logic             valid_q;

    // Reads sample hi_q/lo_q before this edge's write lands, so a read on the
    // writeback edge still returns the previous product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                hi_q <= wr_data[2*WIDTH-1:WIDTH];
                lo_q <= wr_data[WIDTH-1:0];
            end
            if (rd_hi) begin
                bus_q <= hi_q;
            end else if (rd_lo) begin
                bus_q <= lo_q;
            end
            valid_q <= rd_hi | rd_lo;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign bus_out   = bus_q;
    assign bus_valid = valid_q;

endmodule

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - operand capture, settle-and-write FSM around an external multiplier
module mul_hilo_ctrl
    import mul_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m_in,
    input  logic [WIDTH-1:0]     q_in,
    output logic [WIDTH-1:0]     mul_m,
    output logic [WIDTH-1:0]     mul_q,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    input  logic                 rd_hi,
    input  logic                 rd_lo,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid
);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  mul_m_q, mul_q_q;
    logic              done_q;

    // Operands stay on the multiplier inputs after completion; only a new
    // accepted start replaces them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_m_q <= '0;
            mul_q_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mul_m_q <= m_in;
                        mul_q_q <= q_in;
                        cnt_q   <= CNT_W'(LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= WRITE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_m = mul_m_q;
    assign mul_q = mul_q_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

    hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (state_q == WRITE),
        .wr_data   (mul_result),
        .rd_hi     (rd_hi),
        .rd_lo     (rd_lo),
        .hi        (hi),
        .lo        (lo),
        .bus_out   (bus_out),
        .bus_valid (bus_valid)
    );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - randomized and directed bench for mul_hilo_ctrl at LAT 2, 1 and 15
module tb_mul_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] m_in = '0, q_in = '0;
    logic        rd_hi = 1'b0, rd_lo = 1'b0;

    logic [31:0] w_mm[3], w_mq[3], w_hi[3], w_lo[3], w_bus[3];
    logic [63:0] w_res[3];
    logic        w_busy[3], w_done[3], w_valid[3];

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign w_res[g] = smul(w_mm[g], w_mq[g]);
        mul_hilo_ctrl #(.WIDTH(32), .LAT(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .m_in       (m_in),
            .q_in       (q_in),
            .mul_m      (w_mm[g]),
            .mul_q      (w_mq[g]),
            .mul_result (w_res[g]),
            .busy       (w_busy[g]),
            .done       (w_done[g]),
            .hi         (w_hi[g]),
            .lo         (w_lo[g]),
            .rd_hi      (rd_hi),
            .rd_lo      (rd_lo),
            .bus_out    (w_bus[g]),
            .bus_valid  (w_valid[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: each op completes at a known edge number (start edge + LAT + 1);
    // the instance is idle once that edge has passed.
    int          lat[3] = '{2, 1, 15};
    int          edge_no = 0;
    bit          m_active[3];
    int          m_wr_edge[3];
    logic [31:0] m_om[3], m_oq[3], m_hi[3], m_lo[3], m_bus[3];
    logic        m_done[3], m_valid[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_active[i] = 0; m_wr_edge[i] = 0;
                m_om[i] = '0; m_oq[i] = '0; m_hi[i] = '0; m_lo[i] = '0; m_bus[i] = '0;
                m_done[i] = 0; m_valid[i] = 0;
            end
        end else begin
            edge_no++;
            for (int i = 0; i < 3; i++) begin
                logic [31:0] pre_hi, pre_lo;
                logic [63:0] p;
                pre_hi = m_hi[i];
                pre_lo = m_lo[i];
                m_done[i] = 0;
                if (m_active[i] && edge_no == m_wr_edge[i]) begin
                    p = smul(m_om[i], m_oq[i]);
                    m_hi[i] = p[63:32];
                    m_lo[i] = p[31:0];
                    m_done[i] = 1;
                    m_active[i] = 0;
                end else if (!m_active[i] && start) begin
                    m_om[i] = m_in;
                    m_oq[i] = q_in;
                    m_active[i] = 1;
                    m_wr_edge[i] = edge_no + lat[i] + 1;
                end
                m_valid[i] = rd_hi | rd_lo;
                if (rd_hi) m_bus[i] = pre_hi;
                else if (rd_lo) m_bus[i] = pre_lo;
            end
        end
    end

    always @(posedge clk) begin
        #3;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy[%0d]", i), 64'(w_busy[i]), 64'(m_active[i]));
                chk($sformatf("done[%0d]", i), 64'(w_done[i]), 64'(m_done[i]));
                chk($sformatf("mul_m[%0d]", i), 64'(w_mm[i]), 64'(m_om[i]));
                chk($sformatf("mul_q[%0d]", i), 64'(w_mq[i]), 64'(m_oq[i]));
                chk($sformatf("hi[%0d]", i), 64'(w_hi[i]), 64'(m_hi[i]));
                chk($sformatf("lo[%0d]", i), 64'(w_lo[i]), 64'(m_lo[i]));
                chk($sformatf("bus_valid[%0d]", i), 64'(w_valid[i]), 64'(m_valid[i]));
                chk($sformatf("bus_out[%0d]", i), 64'(w_bus[i]), 64'(m_bus[i]));
            end
        end
    end

    task automatic start_op(input logic [31:0] m, input logic [31:0] q);
        start = 1'b1; m_in = m; q_in = q;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (w_done[0]) got = 1;
            else @(negedge clk);
        end
        chk("done_seen", 64'(got), 64'd1);
    endtask

    initial begin
        int dc[3];
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(w_hi[0]), 64'd0);
        chk("rst_busy", 64'(w_busy[0]), 64'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // reset in the middle of WAIT
        start_op(32'd5, 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(w_busy[0]), 64'd0);
        chk("midrst_lo", 64'(w_lo[1]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // -53 * -62
        start_op(32'hFFFF_FFCB, 32'hFFFF_FFC2);
        wait_done();
        chk("t2_hi", 64'(w_hi[0]), 64'h0);
        chk("t2_lo", 64'(w_lo[0]), 64'h0000_0CD6);
        @(negedge clk);
        rd_lo = 1'b1;
        @(negedge clk);
        rd_lo = 1'b0;
        chk("t2_bus", 64'(w_bus[0]), 64'h0000_0CD6);
        chk("t2_valid", 64'(w_valid[0]), 64'd1);
        @(negedge clk);
        chk("t2_valid_drop", 64'(w_valid[0]), 64'd0);

        // max positive square, then a back-to-back start in the done cycle
        start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_done();
        chk("t3a_hi", 64'(w_hi[0]), 64'h3FFF_FFFF);
        chk("t3a_lo", 64'(w_lo[0]), 64'h0000_0001);
        start_op(32'hFFFF_FFFF, 32'h0000_0001);
        chk("t3b_accept", 64'(w_busy[0]), 64'd1);
        wait_done();
        chk("t3b_hi", 64'(w_hi[0]), 64'hFFFF_FFFF);
        chk("t3b_lo", 64'(w_lo[0]), 64'hFFFF_FFFF);
        @(negedge clk);

        // start during WAIT is ignored
        start_op(32'd3, 32'hFFFF_FFFC);
        start_op(32'd100, 32'd100);
        chk("t4_mul_m", 64'(w_mm[0]), 64'd3);
        chk("t4_mul_q", 64'(w_mq[0]), 64'hFFFF_FFFC);
        wait_done();
        chk("t4_hi", 64'(w_hi[0]), 64'hFFFF_FFFF);
        chk("t4_lo", 64'(w_lo[0]), 64'hFFFF_FFF4);
        repeat (20) @(negedge clk);

        // simultaneous read requests: HI wins
        start_op(32'hFFFF_FFFF, 32'h0000_0001);
        wait_done();
        rd_hi = 1'b1; rd_lo = 1'b1;
        @(negedge clk);
        rd_hi = 1'b0; rd_lo = 1'b0;
        chk("t5_bus_hi", 64'(w_bus[0]), 64'hFFFF_FFFF);
        chk("t5_valid", 64'(w_valid[0]), 64'd1);
        // read sampled on the writeback edge sees the old LO
        start_op(32'd2, 32'd3);
        repeat (2) @(negedge clk);
        rd_lo = 1'b1;
        @(negedge clk);
        rd_lo = 1'b0;
        chk("t5_done", 64'(w_done[0]), 64'd1);
        chk("t5_old_lo", 64'(w_bus[0]), 64'hFFFF_FFFF);
        chk("t5_new_lo", 64'(w_lo[0]), 64'd6);
        repeat (20) @(negedge clk);

        // latency per build
        dc = '{0, 0, 0};
        start = 1'b1; m_in = 32'h1234_5678; q_in = 32'hFFFF_FFFE;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 3; i++)
                if (w_done[i] && dc[i] == 0) dc[i] = c;
        end
        chk("t6_lat2", 64'(dc[0]), 64'd4);
        chk("t6_lat1", 64'(dc[1]), 64'd3);
        chk("t6_lat15", 64'(dc[2]), 64'd17);
        chk("t6_hi1", 64'(w_hi[1]), 64'hFFFF_FFFF);
        chk("t6_lo1", 64'(w_lo[1]), 64'hDB97_5310);
        chk("t6_lo15", 64'(w_lo[2]), 64'hDB97_5310);

        // randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            start = ($urandom_range(0, 3) == 0);
            m_in  = $urandom;
            q_in  = $urandom;
            rd_hi = ($urandom_range(0, 3) == 0);
            rd_lo = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        start = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
